// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack, instruction register.
// Hands decoded MIPS fields downstream under valid/ready.
module instr_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              halt,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              halted,
  output logic [15:0]       ins_count
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic              take;
  logic              give;

  // req only ever rises in FETCH, so ack outside a request is ignored
  assign take = imem_req & imem_ack;
  assign give = ins_valid & ins_ready;

  always_comb begin
    state_n = state;
    unique case (1'b1)
      state == S_FETCH: if (take) state_n = S_HOLD;
      state == S_HOLD:
        if (give) state_n = halt ? S_HALTED : S_FETCH;
      default: state_n = S_HALTED;
    endcase
  end

  // handshake outputs are registered off the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      ins_pc    <= '0;
      imem_req  <= 1'b0;
      ins_valid <= 1'b0;
      halted    <= 1'b0;
      ins_count <= '0;
    end else begin
      state     <= state_n;
      imem_req  <= state_n == S_FETCH;
      ins_valid <= state_n == S_HOLD;
      halted    <= state_n == S_HALTED;
      if (take) begin
        ir     <= imem_rdata;
        ins_pc <= pc;
        pc     <= pc + ADDR_W'(PC_STEP);
      end
      if (give) ins_count <= ins_count + 16'd1;
    end
  end

  assign imem_addr = pc;
  assign op        = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign shamt     = ir[10:6];
  assign funct     = ir[5:0];
  assign imm       = ir[15:0];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench for instr_fetch_stage against a transaction model.
// A second instance with a near-top RESET_PC covers PC wrap.
module tb_instr_fetch_stage;

  localparam logic [31:0] RW = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ack = 1'b0;
  logic ready = 1'b0;
  logic halt = 1'b0;
  logic [31:0] rdata = '0;

  logic        req, valid, hltd;
  logic [31:0] addr, ipc;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm, cnt_o;

  logic        w_req, w_valid, w_hltd;
  logic [31:0] w_addr, w_ipc;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm, w_cnt;

  instr_fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(req), .imem_addr(addr),
    .imem_ack(ack), .imem_rdata(rdata),
    .halt(halt), .ins_valid(valid), .ins_ready(ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm),
    .ins_pc(ipc), .halted(hltd), .ins_count(cnt_o)
  );

  instr_fetch_stage #(.RESET_PC(RW)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(ack), .imem_rdata(rdata),
    .halt(halt), .ins_valid(w_valid), .ins_ready(ready),
    .op(w_op), .rs(w_rs), .rt(w_rt), .rd(w_rd),
    .shamt(w_shamt), .funct(w_funct), .imm(w_imm),
    .ins_pc(w_ipc), .halted(w_hltd), .ins_count(w_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  logic [31:0] exp_addr, exp_addr_w, hw, hp, hpw;
  bit          held, hlt, fresh;
  int unsigned cnt, k, wait_left;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic reset_model();
    exp_addr   = 32'd0;
    exp_addr_w = RW;
    held       = 1'b0;
    hlt        = 1'b0;
    fresh      = 1'b1;
    cnt        = 0;
    k          = 0;
    wait_left  = 0;
  endtask

  function automatic bit req_exp();
    return !held && !hlt && !fresh;
  endfunction

  task automatic check_state();
    chk("req", 32'(req), 32'(req_exp()));
    chk("valid", 32'(valid), 32'(held));
    chk("halted", 32'(hltd), 32'(hlt));
    chk("count", 32'(cnt_o), {16'd0, cnt[15:0]});
    chk("w_valid", 32'(w_valid), 32'(held));
    if (req_exp()) begin
      chk("addr", addr, exp_addr);
      chk("w_addr", w_addr, exp_addr_w);
    end
    if (held) begin
      chk("op", 32'(op), 32'(hw[31:26]));
      chk("rs", 32'(rs), 32'(hw[25:21]));
      chk("rt", 32'(rt), 32'(hw[20:16]));
      chk("rd", 32'(rd), 32'(hw[15:11]));
      chk("shamt", 32'(shamt), 32'(hw[10:6]));
      chk("funct", 32'(funct), 32'(hw[5:0]));
      chk("imm", 32'(imm), 32'(hw[15:0]));
      chk("ins_pc", ipc, hp);
      chk("w_ins_pc", w_ipc, hpw);
    end
  endtask

  // one clock: check, drive inputs from the model, update it, advance
  task automatic cycle(input bit allow_halt);
    check_state();
    if (req_exp()) begin
      if (wait_left == 0) begin
        ack = 1'b1;
        if (k == 0) rdata = 32'h0022_1820;
        else if (k == 1) rdata = 32'h2062_FFFF;
        else rdata = $urandom;
      end else begin
        ack = 1'b0;
        rdata = $urandom;
        wait_left--;
      end
    end else begin
      ack = 1'($urandom % 2);
      rdata = $urandom;
    end
    ready = ($urandom % 4) != 0;
    if (allow_halt) halt = 1'($urandom % 2);
    else halt = held ? 1'b0 : 1'($urandom % 2);
    if (req_exp() && ack) begin
      hw = rdata;
      hp = exp_addr;
      hpw = exp_addr_w;
      exp_addr = exp_addr + 32'd4;
      exp_addr_w = exp_addr_w + 32'd4;
      held = 1'b1;
      k++;
      wait_left = $urandom % 4;
    end else if (held && ready) begin
      held = 1'b0;
      cnt++;
      if (halt) hlt = 1'b1;
    end
    fresh = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_halted", 32'(hltd), 32'd0);
    chk("rst_count", 32'(cnt_o), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_ins_pc", ipc, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_w_addr", w_addr, RW);
    rst = 1'b0;

    repeat (300) cycle(1'b0);
    repeat (60) cycle(1'b1);
    chk("halt_seen", 32'(hlt), 32'd1);

    rst = 1'b1;
    @(posedge clk);
    #1;
    reset_model();
    rst = 1'b0;
    repeat (20) cycle(1'b0);
    n = 0;
    while (!held && n < 20) begin
      cycle(1'b0);
      n++;
    end
    chk("reach_hold", 32'(held), 32'd1);
    rst = 1'b1;
    ready = 1'b1;
    ack = 1'b1;
    halt = 1'b0;
    @(posedge clk);
    #1;
    reset_model();
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_count", 32'(cnt_o), 32'd0);
    chk("mid_rst_addr", addr, 32'd0);
    chk("mid_rst_req", 32'(req), 32'd0);
    rst = 1'b0;
    repeat (40) cycle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
